// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the bit-granular width-converting FIFO.
//   DEPTH_BITS_DEFAULT : default storage capacity in bits
//   W_WIDTH_DEFAULT    : default write symbol width
//   R_WIDTH_DEFAULT    : default read word width
//   count_width()      : width needed to hold a bit count of 0..depth
//   mod_add()          : wrapped pointer addition
package fifo_pkg;

    localparam int unsigned DEPTH_BITS_DEFAULT = 128;
    localparam int unsigned W_WIDTH_DEFAULT    = 3;
    localparam int unsigned R_WIDTH_DEFAULT    = 8;

    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    localparam int unsigned COUNT_W_DEFAULT = count_width(DEPTH_BITS_DEFAULT);

    // Depth need not be a power of two, so wrap with a true modulo.
    function automatic int unsigned mod_add(input int unsigned a, input int unsigned b,
                                            input int unsigned m);
        return (a + b) % m;
    endfunction

endpackage

// File: rtl/fifo_bitring.sv
// Bit ring memory: writes W_WIDTH bits starting at wr_ptr_i and presents R_WIDTH bits
// starting at rd_ptr_i, both offsets wrapping modulo DEPTH_BITS. Bit j of each word maps to
// ring position ptr+j, so the LSB is the oldest/first bit.
//   clk      : clock
//   we_i     : write strobe (already qualified by the caller)
//   wr_ptr_i : bit index of the first written bit
//   wdata_i  : write symbol
//   rd_ptr_i : bit index of the oldest bit
//   rdata_o  : combinational read word
module fifo_bitring import fifo_pkg::*; #(
    parameter int unsigned DEPTH_BITS = DEPTH_BITS_DEFAULT,
    parameter int unsigned W_WIDTH    = W_WIDTH_DEFAULT,
    parameter int unsigned R_WIDTH    = R_WIDTH_DEFAULT,
    parameter int unsigned PtrW       = 7
) (
    input  logic               clk,
    input  logic               we_i,
    input  logic [PtrW-1:0]    wr_ptr_i,
    input  logic [W_WIDTH-1:0] wdata_i,
    input  logic [PtrW-1:0]    rd_ptr_i,
    output logic [R_WIDTH-1:0] rdata_o
);

    logic [DEPTH_BITS-1:0] mem_q, mem_d;

    always_comb begin
        mem_d = mem_q;
        if (we_i) begin
            for (int unsigned j = 0; j < W_WIDTH; j++) begin
                mem_d[PtrW'(mod_add(32'(wr_ptr_i), j, DEPTH_BITS))] = wdata_i[j];
            end
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int unsigned j = 0; j < R_WIDTH; j++) begin
            rdata_o[j] = mem_q[PtrW'(mod_add(32'(rd_ptr_i), j, DEPTH_BITS))];
        end
    end

    // Storage contents are don't-care after reset; only the pointers matter.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/fifo_3to8.sv
// Width-converting FIFO: 3-bit symbols in, 8-bit bytes out, bit-granular storage.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   w_en      : write request, accepted when not full
//   data_w    : write symbol (LSB stored first)
//   r_en      : read request, accepted when not empty
//   data_r    : registered read byte, bit 0 = oldest bit; holds when no read accepted
//   empty     : fewer than R_WIDTH bits stored
//   half_full : count >= DEPTH_BITS/2 and not full
//   full      : free space < W_WIDTH
//   overflow  : sticky, set by write while full, cleared by an accepted read
//   underflow : sticky, set by read while empty, cleared by an accepted write
module fifo_3to8 import fifo_pkg::*; #(
    parameter int unsigned DEPTH_BITS = DEPTH_BITS_DEFAULT,
    parameter int unsigned W_WIDTH    = W_WIDTH_DEFAULT,
    parameter int unsigned R_WIDTH    = R_WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               w_en,
    input  logic [W_WIDTH-1:0] data_w,
    input  logic               r_en,
    output logic [R_WIDTH-1:0] data_r,
    output logic               empty,
    output logic               half_full,
    output logic               full,
    output logic               overflow,
    output logic               underflow
);

    localparam int unsigned CountW = count_width(DEPTH_BITS);
    localparam int unsigned PtrW   = (DEPTH_BITS > 1) ? $clog2(DEPTH_BITS) : 1;

    logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CountW-1:0]  count_q, count_d;
    logic [R_WIDTH-1:0] data_r_q, data_r_d, ring_rdata;
    logic               overflow_q, overflow_d, underflow_q, underflow_d;
    logic               wr_ok, rd_ok, ring_we;

    always_comb begin
        empty     = count_q < CountW'(R_WIDTH);
        full      = (CountW'(DEPTH_BITS) - count_q) < CountW'(W_WIDTH);
        half_full = (count_q >= CountW'(DEPTH_BITS / 2)) && !full;
        data_r    = data_r_q;
        overflow  = overflow_q;
        underflow = underflow_q;
    end

    assign wr_ok   = w_en && !full;
    assign rd_ok   = r_en && !empty;
    // Keep reset from disturbing storage even though it would be unobservable.
    assign ring_we = wr_ok && !rst;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        data_r_d    = data_r_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_ok) begin
            wr_ptr_d = PtrW'(mod_add(32'(wr_ptr_q), W_WIDTH, DEPTH_BITS));
            count_d  = count_d + CountW'(W_WIDTH);
        end
        if (rd_ok) begin
            rd_ptr_d = PtrW'(mod_add(32'(rd_ptr_q), R_WIDTH, DEPTH_BITS));
            count_d  = count_d - CountW'(R_WIDTH);
            data_r_d = ring_rdata;
        end

        // Setting wins over clearing when both happen in one cycle.
        if (w_en && full) begin
            overflow_d = 1'b1;
        end else if (rd_ok) begin
            overflow_d = 1'b0;
        end

        if (r_en && empty) begin
            underflow_d = 1'b1;
        end else if (wr_ok) begin
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_r_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_r_q    <= data_r_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_bitring #(
        .DEPTH_BITS (DEPTH_BITS),
        .W_WIDTH    (W_WIDTH),
        .R_WIDTH    (R_WIDTH),
        .PtrW       (PtrW)
    ) u_ring (
        .clk      (clk),
        .we_i     (ring_we),
        .wr_ptr_i (wr_ptr_q),
        .wdata_i  (data_w),
        .rd_ptr_i (rd_ptr_q),
        .rdata_o  (ring_rdata)
    );

endmodule

// File: tb/tb_fifo_3to8.sv
// Self-checking bench for fifo_3to8. A bit-queue reference model tracks the stored bits,
// data_r and the sticky flags; every cycle the DUT outputs are compared with it, plus a
// short table of hand-derived vectors and explicit corner-case checks.
module tb_fifo_3to8;

    localparam int DEPTH = 128;
    localparam int WW    = 3;
    localparam int RW    = 8;

    logic       clk = 1'b0;
    logic       rst, w_en, r_en;
    logic [2:0] data_w;
    logic [7:0] data_r;
    logic       empty, half_full, full, overflow, underflow;
    logic [12:0] dut_vec;

    always #5 clk = ~clk;

    fifo_3to8 dut (
        .clk       (clk),
        .rst       (rst),
        .w_en      (w_en),
        .data_w    (data_w),
        .r_en      (r_en),
        .data_r    (data_r),
        .empty     (empty),
        .half_full (half_full),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    assign dut_vec = {data_r, empty, half_full, full, overflow, underflow};

    // Reference model
    bit         mq[$];
    logic [7:0] m_data;
    logic       m_ovf, m_udf;

    int n_chk, n_pass;

    typedef struct {
        logic       w;
        logic [2:0] d;
        logic       r;
        logic [7:0] exp_data;
        logic [4:0] exp_flags;  // {empty, half_full, full, overflow, underflow}
    } vec_t;

    vec_t tbl[6];

    function automatic bit model_full();
        return (DEPTH - mq.size()) < WW;
    endfunction

    function automatic bit model_empty();
        return mq.size() < RW;
    endfunction

    function automatic logic [12:0] model_vec();
        logic hf;
        hf = (mq.size() >= DEPTH / 2) && !model_full();
        return {m_data, model_empty(), hf, model_full(), m_ovf, m_udf};
    endfunction

    task automatic model_clear();
        mq.delete();
        m_data = 8'h00;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
    endtask

    task automatic model_edge(input logic w, input logic [2:0] d, input logic r);
        bit f, e, wr_ok, rd_ok;
        f     = model_full();
        e     = model_empty();
        wr_ok = w && !f;
        rd_ok = r && !e;
        if (w && f) m_ovf = 1'b1;
        else if (rd_ok) m_ovf = 1'b0;
        if (r && e) m_udf = 1'b1;
        else if (wr_ok) m_udf = 1'b0;
        if (rd_ok) begin
            for (int j = 0; j < RW; j++) m_data[j] = mq.pop_front();
        end
        if (wr_ok) begin
            for (int j = 0; j < WW; j++) mq.push_back(d[j]);
        end
    endtask

    task automatic check(input string name, input logic [12:0] got, input logic [12:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h required %h (t=%0t)", name, got, exp, $time);
    endtask

    // Drive one cycle of inputs, advance the model, compare all outputs.
    task automatic step(input logic w, input logic [2:0] d, input logic r, input string name);
        w_en   = w;
        data_w = d;
        r_en   = r;
        @(posedge clk);
        model_edge(w, d, r);
        #1;
        check(name, dut_vec, model_vec());
    endtask

    task automatic do_reset(input int n, input logic w, input logic r, input string name);
        rst    = 1'b1;
        w_en   = w;
        r_en   = r;
        data_w = 3'($urandom);
        repeat (n) @(posedge clk);
        model_clear();
        #1;
        rst  = 1'b0;
        w_en = 1'b0;
        r_en = 1'b0;
        check(name, dut_vec, {8'h00, 5'b10000});
    endtask

    task automatic write_n(input int n, input string name);
        for (int i = 0; i < n; i++) step(1'b1, 3'($urandom), 1'b0, name);
    endtask

    task automatic read_n(input int n, input string name);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, 1'b1, name);
    endtask

    initial begin
        rst    = 1'b1;
        w_en   = 1'b0;
        r_en   = 1'b0;
        data_w = 3'd0;
        n_chk  = 0;
        n_pass = 0;
        model_clear();

        // Reset, underflow on empty read, packing order 5,2,7 -> 0xD5
        tbl[0] = '{1'b0, 3'd0, 1'b1, 8'h00, 5'b10001};
        tbl[1] = '{1'b1, 3'd5, 1'b0, 8'h00, 5'b10000};
        tbl[2] = '{1'b1, 3'd2, 1'b0, 8'h00, 5'b10000};
        tbl[3] = '{1'b1, 3'd7, 1'b0, 8'h00, 5'b00000};
        tbl[4] = '{1'b0, 3'd0, 1'b1, 8'hD5, 5'b10000};
        tbl[5] = '{1'b0, 3'd0, 1'b0, 8'hD5, 5'b10000};

        do_reset(2, 1'b0, 1'b0, "reset");
        for (int i = 0; i < 6; i++) begin
            step(tbl[i].w, tbl[i].d, tbl[i].r, $sformatf("model_tbl[%0d]", i));
            check($sformatf("table[%0d]", i), dut_vec, {tbl[i].exp_data, tbl[i].exp_flags});
        end

        // Fill and flag thresholds
        do_reset(1, 1'b0, 1'b0, "reset_fill");
        for (int i = 1; i <= 42; i++) begin
            step(1'b1, 3'($urandom), 1'b0, "fill");
            if (i == 21) check("hf_at_63", 13'(half_full), 13'd0);
            if (i == 22) check("hf_at_66", 13'(half_full), 13'd1);
            if (i == 41) check("not_full_123", 13'(full), 13'd0);
            if (i == 42) check("full_126", 13'({full, half_full}), 13'b10);
        end

        // Overflow: rejected write, then a read clears the flag
        step(1'b1, 3'd6, 1'b0, "ovf_write");
        check("ovf_set", 13'({overflow, full}), 13'b11);
        step(1'b0, 3'd0, 1'b1, "ovf_read");
        check("ovf_clear", 13'({overflow, full, empty}), 13'b000);
        while (mq.size() >= RW) step(1'b0, 3'd0, 1'b1, "drain_after_ovf");

        // Wrap-around: refill to 126, read 15, write 40, drain
        while (!model_full()) step(1'b1, 3'($urandom), 1'b0, "wrap_fill");
        read_n(15, "wrap_read");
        write_n(40, "wrap_write");
        while (!model_empty()) step(1'b0, 3'd0, 1'b1, "wrap_drain");
        check("wrap_empty", 13'(empty), 13'd1);

        // Underflow straight after reset
        do_reset(1, 1'b0, 1'b0, "reset_udf");
        step(1'b0, 3'd0, 1'b1, "udf");
        check("udf_after_reset", {data_r, 4'b0000, underflow}, {8'h00, 4'b0000, 1'b1});

        // Simultaneous read and write at count 8
        do_reset(1, 1'b0, 1'b0, "reset_simul");
        write_n(8, "simul_fill");
        read_n(2, "simul_pre");
        check("count8_not_empty", 13'(empty), 13'd0);
        step(1'b1, 3'($urandom), 1'b1, "simul");
        check("simul_flags", 13'({empty, full, underflow}), 13'b100);

        // Randomized traffic with varying bias
        do_reset(1, 1'b0, 1'b0, "reset_rand");
        for (int i = 0; i < 1200; i++) begin
            int unsigned wp;
            wp = (i / 200) % 2 == 0 ? 70 : 30;
            step(1'($urandom_range(99, 0) < wp), 3'($urandom),
                 1'($urandom_range(99, 0) >= wp - 10), "random");
        end

        // Reset mid-operation at count 50 with both requests active
        do_reset(1, 1'b0, 1'b0, "reset_pre50");
        write_n(22, "to50_w");
        read_n(2, "to50_r");
        check("count50_flags", 13'({empty, half_full, full}), 13'b000);
        do_reset(1, 1'b1, 1'b1, "reset_mid_op");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fifo_3to8.md
Name: fifo_3to8

Overview:
- Bit-granular width-converting FIFO, the reverse of the existing 8-in/3-out packing FIFO.
- Accepts 3-bit symbols on the write side and delivers 8-bit bytes on the read side.
- Used where a 3-bit symbol stream must be reassembled into bytes.
- Status flags (empty, half_full, full, overflow) keep the same meaning as the 8-to-3 FIFO; underflow is added.

Parameters:
- DEPTH_BITS, 128: storage capacity in bits.
- W_WIDTH, 3: write word width in bits.
- R_WIDTH, 8: read word width in bits.

Ports:
- clk  in  1  single clock; all logic updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- w_en  in  1  write request.
- data_w  in  W_WIDTH  write symbol.
- r_en  in  1  read request.
- data_r  out  R_WIDTH  read byte, registered.
- empty  out  1  fewer than R_WIDTH bits stored.
- half_full  out  1  count >= DEPTH_BITS/2 and not full.
- full  out  1  free space < W_WIDTH.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

Behaviour:
- State: bit ring buffer mem[DEPTH_BITS]; wr_ptr and rd_ptr are bit indices modulo DEPTH_BITS; count has width clog2(DEPTH_BITS+1).
- Reset: count=0, both pointers 0, data_r=0, empty=1. half_full, full, overflow and underflow are 0. Reset takes priority over everything, including mid-operation.
- Bit order: data_w[j] is stored at mem[(wr_ptr+j) mod DEPTH_BITS], so the LSB is written first. data_r[j] is the j-th oldest stored bit. Pointer increments wrap modulo DEPTH_BITS; DEPTH_BITS need not be a multiple of either width.
- Write accept: wr_ok = w_en && !full, evaluated on pre-edge state. On accept, wr_ptr += W_WIDTH.
- Read accept: rd_ok = r_en && !empty, evaluated on pre-edge state. On accept, data_r loads the byte at the next edge (1-cycle latency) and rd_ptr += R_WIDTH.
- data_r holds its value when no read is accepted.
- Simultaneous read and write: both are judged independently on pre-edge state. The next count is count + W_WIDTH*wr_ok − R_WIDTH*rd_ok.
- Flags are combinational from the registered count:
  - empty = count < R_WIDTH
  - full = (DEPTH_BITS − count) < W_WIDTH
  - half_full = count >= DEPTH_BITS/2 && !full
- overflow:
  - Set at the edge after w_en && full.
  - Cleared at the edge of any accepted read.
  - Set takes priority if both occur in the same cycle.
  - A rejected write leaves memory and count unchanged.
- underflow:
  - Set at the edge after r_en && empty.
  - Cleared at the edge of any accepted write.
  - A rejected read leaves data_r unchanged.
- No state machine beyond the pointers and count. The flags are the only control.

Decomposition:
- Package fifo_pkg holds:
  - default DEPTH_BITS, W_WIDTH and R_WIDTH constants;
  - the count width derived via clog2;
  - a mod-add function for pointer wrap.
- Sub-module fifo_bitring: the bit memory with multi-bit write and read at arbitrary wrapped offsets. fifo_3to8 keeps the pointers, count, flags and data_r.

Test Plan:
- Reset: hold rst for 2 cycles, release. Required: empty=1, half_full=0, full=0, overflow=0, underflow=0, data_r=0.
- Packing and order:
  - Stimulus: write 3'd5, 3'd2, 3'd7, then r_en for one cycle.
  - Required: data_r=8'hD5 the cycle after the read; count=1; empty=1.
- Fill and flags:
  - Write 21 symbols (63 bits): half_full=0.
  - 22nd write (66 bits): half_full=1.
  - 42nd write (126 bits): full=1 and half_full=0.
- Overflow:
  - At count 126, pulse w_en with 3'd6. Required: overflow=1 next cycle, count stays 126, data unchanged.
  - Then one read. Required: count=118, full=0, overflow=0.
- Wrap-around:
  - Fill to 126 bits, read 15 bytes, write 40 further symbols (pointers wrap), drain all.
  - Every data_r must match a bit-queue reference model; end state empty=1.
- Underflow, simultaneous access, reset:
  - After reset, r_en=1. Required: underflow=1, data_r=0.
  - At count=8, assert r_en and w_en together. Required: count=3, empty=1, byte correct.
  - Assert rst at count=50. Required: all outputs at reset values the next cycle.
